cache_arbiter: RTL and testbench
================================

CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 Parameter: LINE_W, 256, cacheline width in bits.
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  in  1  synchronous, active-high reset.
REQ-004 Ports, I-side: icache_read in 1 (read request); icache_address in 32 (line address); icache_rdata out LINE_W (fill data); icache_resp out 1 (done pulse).
REQ-005 Ports, D-side: dcache_read in 1; dcache_write in 1; dcache_address in 32; dcache_wdata in LINE_W; dcache_rdata out LINE_W; dcache_resp out 1.
REQ-006 Ports, memory side: pmem_read out 1; pmem_write out 1; pmem_address out 32; pmem_wdata out LINE_W; pmem_rdata in LINE_W; pmem_resp in 1 (one-cycle completion pulse).

Function
REQ-007 The block shall time-share the single memory port between the I-cache and D-cache, with at most one transaction outstanding.
REQ-008 FSM states: IDLE, MEM_I, MEM_D, RESP.
REQ-009 IDLE: the block samples requests; no request -> stay IDLE; only I pending -> MEM_I; only D pending (read or write) -> MEM_D.
REQ-010 Both pending in IDLE: the side NOT granted last wins (round-robin via a last_grant bit; reset value = I, so D wins the first tie).
REQ-011 On grant, the block registers address, direction and wdata; later requester input changes have no effect until the next grant.
REQ-012 D-side with read and write both high: write wins; the read is served as a separate later grant.
REQ-013 MEM_I / MEM_D: pmem_read or pmem_write is held high with stable address/wdata from the cycle after the grant edge until the cycle pmem_resp is sampled high.
REQ-014 pmem_read and pmem_write are never both high.
REQ-015 On pmem_resp=1 in MEM_x: register pmem_rdata into x_rdata, update last_grant, go to RESP.
REQ-016 RESP lasts exactly one cycle, asserts the granted side's resp only, then returns to IDLE.
REQ-017 x_rdata holds its value until the next read completion to that side; on a write completion, dcache_rdata is unchanged.
REQ-018 Latency: request high in IDLE at cycle N -> pmem strobe from N+1 -> pmem_resp at cycle M -> x_resp at M+1 -> IDLE at M+2.
REQ-019 A requester deasserts its request in the cycle after resp; the block samples requests again only in IDLE (M+2), so no duplicate grant occurs.
REQ-020 pmem_resp outside MEM_I/MEM_D shall be ignored.
REQ-021 pmem_address/pmem_wdata are don't-care while both strobes are low.

Reset
REQ-022 With rst high at a clock edge: state = IDLE, last_grant = I, pmem_read = pmem_write = 0, icache_resp = dcache_resp = 0, rdata registers = 0, latched address/wdata = 0.
REQ-023 Reset mid-transaction aborts it: no resp is issued; strobes are low in the cycle after the reset edge; a late pmem_resp is ignored per REQ-020.
REQ-024 rst overrides all other inputs in the same cycle.

Verification
REQ-025 I-read only, address 0x0000_1000, pmem_resp 3 cycles after strobe with rdata = all-0xA5 -> pmem_read=1 with pmem_address=0x1000 for 3 cycles, then icache_resp=1 for one cycle with icache_rdata=all-0xA5, dcache_resp stays 0.
REQ-026 After reset, icache_read and dcache_read rise in the same cycle -> D served first, then I; a repeated tie after that alternates I, D.
REQ-027 dcache_write with address 0x8000_0040, wdata pattern P, dcache_address changed mid-transaction -> pmem_write=1 with pmem_address=0x8000_0040 and pmem_wdata=P throughout; dcache_resp pulses once; dcache_rdata is unchanged.
REQ-028 dcache_read and dcache_write high together -> write transaction first, then a separate read transaction, with one dcache_resp per transaction.
REQ-029 rst asserted during MEM_D with pmem_resp arriving 2 cycles later -> strobes low the cycle after reset, no dcache_resp, FSM stays IDLE.
REQ-030 Back-to-back: the requester re-asserts the cycle after its resp -> new grant at M+2; no duplicate grant for the old request.

Source files
------------

// File: rtl/cache_arbiter_if.sv
// Bundle of I-cache, D-cache and memory-port signals shared by the arbiter.
// The arbiter takes the master view; the caches and memory together take the slave view.
interface cache_arbiter_if #(
    parameter int unsigned LINE_W = 256
) ();
    logic              icache_read;
    logic [31:0]       icache_address;
    logic [LINE_W-1:0] icache_rdata;
    logic              icache_resp;

    logic              dcache_read;
    logic              dcache_write;
    logic [31:0]       dcache_address;
    logic [LINE_W-1:0] dcache_wdata;
    logic [LINE_W-1:0] dcache_rdata;
    logic              dcache_resp;

    logic              pmem_read;
    logic              pmem_write;
    logic [31:0]       pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    modport master (
        input  icache_read, icache_address,
        input  dcache_read, dcache_write, dcache_address, dcache_wdata,
        input  pmem_rdata, pmem_resp,
        output icache_rdata, icache_resp,
        output dcache_rdata, dcache_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata
    );

    modport slave (
        output icache_read, icache_address,
        output dcache_read, dcache_write, dcache_address, dcache_wdata,
        output pmem_rdata, pmem_resp,
        input  icache_rdata, icache_resp,
        input  dcache_rdata, dcache_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata
    );
endinterface

// File: rtl/cache_arbiter.sv
// Time-shares one memory port between I-cache and D-cache, one transaction at a time,
// with round-robin on ties and write-before-read on the D side.
module cache_arbiter #(
    parameter int unsigned LINE_W = 256
) (
    input logic              clk,
    input logic              rst,
    cache_arbiter_if.master  bus
);

    typedef enum logic [1:0] {StIdle, StMemI, StMemD, StResp} state_e;

    state_e            state_q, state_d;
    logic              last_grant_q, last_grant_d;  // 1 = D side granted last
    logic              owner_q, owner_d;            // 1 = D side owns current transaction
    logic              write_q, write_d;
    logic [31:0]       addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic [LINE_W-1:0] irdata_q, irdata_d;
    logic [LINE_W-1:0] drdata_q, drdata_d;

    logic i_pend, d_pend;
    assign i_pend = bus.icache_read;
    assign d_pend = bus.dcache_read | bus.dcache_write;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        write_d      = write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        irdata_d     = irdata_q;
        drdata_d     = drdata_q;
        case (state_q)
            StIdle: begin
                // D wins alone, or on a tie when I was granted last
                if (d_pend && (!i_pend || !last_grant_q)) begin
                    state_d = StMemD;
                    owner_d = 1'b1;
                    write_d = bus.dcache_write;
                    addr_d  = bus.dcache_address;
                    wdata_d = bus.dcache_wdata;
                end else if (i_pend) begin
                    state_d = StMemI;
                    owner_d = 1'b0;
                    write_d = 1'b0;
                    addr_d  = bus.icache_address;
                end
            end
            StMemI: begin
                if (bus.pmem_resp) begin
                    irdata_d     = bus.pmem_rdata;
                    last_grant_d = 1'b0;
                    state_d      = StResp;
                end
            end
            StMemD: begin
                if (bus.pmem_resp) begin
                    if (!write_q) begin
                        drdata_d = bus.pmem_rdata;
                    end
                    last_grant_d = 1'b1;
                    state_d      = StResp;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b0;
            owner_q      <= 1'b0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            irdata_q     <= '0;
            drdata_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            irdata_q     <= irdata_d;
            drdata_q     <= drdata_d;
        end
    end

    assign bus.pmem_read    = (state_q == StMemI) || ((state_q == StMemD) && !write_q);
    assign bus.pmem_write   = (state_q == StMemD) && write_q;
    assign bus.pmem_address = addr_q;
    assign bus.pmem_wdata   = wdata_q;
    assign bus.icache_resp  = (state_q == StResp) && !owner_q;
    assign bus.dcache_resp  = (state_q == StResp) && owner_q;
    assign bus.icache_rdata = irdata_q;
    assign bus.dcache_rdata = drdata_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: a hand-driven memory model with fixed response latency,
// expected values written out per transaction.
module tb_cache_arbiter;
    localparam int unsigned LW = 256;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_failed = 0;

    cache_arbiter_if #(.LINE_W(LW)) bus ();

    cache_arbiter #(.LINE_W(LW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [LW-1:0] pat_a5   = {32{8'hA5}};
    logic [LW-1:0] pat_d1   = {8{32'hD1D1_0001}};
    logic [LW-1:0] pat_d2   = {8{32'hD2D2_0002}};
    logic [LW-1:0] pat_d3   = {8{32'hD3D3_0003}};
    logic [LW-1:0] pat_i1   = {8{32'h1111_0001}};
    logic [LW-1:0] pat_i2   = {8{32'h1212_0002}};
    logic [LW-1:0] pat_p    = {4{64'h0123_4567_89AB_CDEF}};
    logic [LW-1:0] pat_q    = {4{64'hFEDC_BA98_7654_3210}};
    logic [LW-1:0] pat_junk = {16{16'hBEEF}};

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called in the first strobe cycle; checks the strobe each cycle and answers after lat cycles.
    task automatic mem_txn(input string tag, input logic exp_rd, input logic exp_wr,
                           input logic [31:0] exp_addr, input logic [LW-1:0] exp_wdata,
                           input int lat, input logic [LW-1:0] rdata);
        for (int i = 1; i <= lat; i++) begin
            check({tag, " pmem_read"}, LW'(bus.pmem_read), LW'(exp_rd));
            check({tag, " pmem_write"}, LW'(bus.pmem_write), LW'(exp_wr));
            check({tag, " pmem_address"}, LW'(bus.pmem_address), LW'(exp_addr));
            if (exp_wr) check({tag, " pmem_wdata"}, bus.pmem_wdata, exp_wdata);
            if (i == lat) begin
                bus.pmem_resp  = 1'b1;
                bus.pmem_rdata = rdata;
            end
            step();
        end
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.icache_read    = 1'b1;  // held during reset: must be overridden
        bus.icache_address = 32'h0000_1000;
        bus.dcache_read    = 1'b0;
        bus.dcache_write   = 1'b0;
        bus.dcache_address = '0;
        bus.dcache_wdata   = '0;
        bus.pmem_resp      = 1'b0;
        bus.pmem_rdata     = '0;
        rst = 1'b1;
        step();
        step();
        check("rst pmem_read", LW'(bus.pmem_read), LW'(0));
        check("rst pmem_write", LW'(bus.pmem_write), LW'(0));
        check("rst icache_resp", LW'(bus.icache_resp), LW'(0));
        check("rst dcache_resp", LW'(bus.dcache_resp), LW'(0));
        check("rst icache_rdata", bus.icache_rdata, '0);
        check("rst dcache_rdata", bus.dcache_rdata, '0);
        check("rst pmem_address", LW'(bus.pmem_address), LW'(0));

        // Single I-side read, three-cycle memory latency
        rst = 1'b0;
        step();
        mem_txn("i_rd", 1'b1, 1'b0, 32'h0000_1000, '0, 3, pat_a5);
        check("i_rd icache_resp", LW'(bus.icache_resp), LW'(1));
        check("i_rd dcache_resp", LW'(bus.dcache_resp), LW'(0));
        check("i_rd icache_rdata", bus.icache_rdata, pat_a5);
        check("i_rd strobe off in resp", LW'(bus.pmem_read), LW'(0));
        bus.icache_read = 1'b0;
        step();
        check("i_rd resp one cycle", LW'(bus.icache_resp), LW'(0));
        check("i_rd idle pmem_read", LW'(bus.pmem_read), LW'(0));
        step();
        check("i_rd no dup grant", LW'(bus.pmem_read), LW'(0));

        // Tie after reset: D first, then alternation I, D, plus back-to-back re-requests
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.icache_read    = 1'b1;
        bus.icache_address = 32'h0000_2000;
        bus.dcache_read    = 1'b1;
        bus.dcache_address = 32'h0000_3000;
        step();
        mem_txn("tie1_d", 1'b1, 1'b0, 32'h0000_3000, '0, 2, pat_d1);
        check("tie1 dcache_resp", LW'(bus.dcache_resp), LW'(1));
        check("tie1 icache_resp", LW'(bus.icache_resp), LW'(0));
        check("tie1 dcache_rdata", bus.dcache_rdata, pat_d1);
        bus.dcache_address = 32'h0000_3100;
        step();
        step();
        mem_txn("tie2_i", 1'b1, 1'b0, 32'h0000_2000, '0, 1, pat_i1);
        check("tie2 icache_resp", LW'(bus.icache_resp), LW'(1));
        check("tie2 dcache_resp", LW'(bus.dcache_resp), LW'(0));
        check("tie2 icache_rdata", bus.icache_rdata, pat_i1);
        bus.icache_address = 32'h0000_2100;
        step();
        step();
        mem_txn("tie3_d", 1'b1, 1'b0, 32'h0000_3100, '0, 1, pat_d2);
        check("tie3 dcache_resp", LW'(bus.dcache_resp), LW'(1));
        check("tie3 dcache_rdata", bus.dcache_rdata, pat_d2);
        bus.dcache_read = 1'b0;
        step();
        step();
        mem_txn("b2b_i", 1'b1, 1'b0, 32'h0000_2100, '0, 2, pat_i2);
        check("b2b icache_resp", LW'(bus.icache_resp), LW'(1));
        check("b2b icache_rdata", bus.icache_rdata, pat_i2);
        check("b2b dcache_rdata kept", bus.dcache_rdata, pat_d2);
        bus.icache_read = 1'b0;
        step();
        step();
        check("b2b no dup read", LW'(bus.pmem_read), LW'(0));
        check("b2b no dup write", LW'(bus.pmem_write), LW'(0));

        // D write with inputs changing mid-transaction
        bus.dcache_write   = 1'b1;
        bus.dcache_address = 32'h8000_0040;
        bus.dcache_wdata   = pat_p;
        step();
        bus.dcache_address = 32'hDEAD_0000;
        bus.dcache_wdata   = ~pat_p;
        mem_txn("d_wr", 1'b0, 1'b1, 32'h8000_0040, pat_p, 3, pat_junk);
        check("d_wr dcache_resp", LW'(bus.dcache_resp), LW'(1));
        check("d_wr dcache_rdata kept", bus.dcache_rdata, pat_d2);
        bus.dcache_write = 1'b0;
        step();
        check("d_wr resp once", LW'(bus.dcache_resp), LW'(0));
        check("d_wr strobe off", LW'(bus.pmem_write), LW'(0));

        // Read and write together: write first, then the read as its own grant
        bus.dcache_read    = 1'b1;
        bus.dcache_write   = 1'b1;
        bus.dcache_address = 32'h0000_4000;
        bus.dcache_wdata   = pat_q;
        step();
        mem_txn("rw_wr", 1'b0, 1'b1, 32'h0000_4000, pat_q, 1, pat_junk);
        check("rw_wr dcache_resp", LW'(bus.dcache_resp), LW'(1));
        check("rw_wr dcache_rdata kept", bus.dcache_rdata, pat_d2);
        bus.dcache_write = 1'b0;
        step();
        check("rw idle dcache_resp", LW'(bus.dcache_resp), LW'(0));
        step();
        mem_txn("rw_rd", 1'b1, 1'b0, 32'h0000_4000, '0, 2, pat_d3);
        check("rw_rd dcache_resp", LW'(bus.dcache_resp), LW'(1));
        check("rw_rd dcache_rdata", bus.dcache_rdata, pat_d3);
        bus.dcache_read = 1'b0;
        step();

        // Reset during MEM_D with a late pmem_resp
        bus.dcache_read    = 1'b1;
        bus.dcache_address = 32'h0000_5000;
        step();
        check("abort pmem_read before rst", LW'(bus.pmem_read), LW'(1));
        rst = 1'b1;
        bus.dcache_read = 1'b0;
        step();
        rst = 1'b0;
        check("abort pmem_read", LW'(bus.pmem_read), LW'(0));
        check("abort pmem_write", LW'(bus.pmem_write), LW'(0));
        check("abort dcache_resp", LW'(bus.dcache_resp), LW'(0));
        check("abort dcache_rdata", bus.dcache_rdata, '0);
        step();
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = pat_junk;
        step();
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = '0;
        check("late resp dcache_resp", LW'(bus.dcache_resp), LW'(0));
        check("late resp pmem_read", LW'(bus.pmem_read), LW'(0));
        check("late resp dcache_rdata", bus.dcache_rdata, '0);
        step();
        check("late resp idle dresp", LW'(bus.dcache_resp), LW'(0));
        check("late resp idle iresp", LW'(bus.icache_resp), LW'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end
endmodule
